// File: rtl/ddr_page_scheduler.sv
// rtl/ddr_page_scheduler.sv - DDR audio frame-page pool arbiter: one writer, one reader
// Writer never touches the page being read; reader always gets the newest completed frame.
module ddr_page_scheduler #(
  parameter int PAGE_NUM = 4,
  parameter int PAGE_W   = 4,
  parameter int DROP_W   = 16
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  input  logic              DDR_INIT_DONE,
  input  logic              wr_req,
  output logic              wr_gnt,
  output logic [PAGE_W-1:0] wr_page,
  output logic              wr_busy,
  input  logic              wr_done,
  input  logic              rd_req,
  output logic              rd_gnt,
  output logic [PAGE_W-1:0] rd_page,
  output logic              rd_fresh,
  output logic              rd_busy,
  input  logic              rd_done,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              proto_err
);

  logic              r_wr_gnt;
  logic              r_wr_busy;
  logic [PAGE_W-1:0] r_wr_page;
  logic              r_rd_gnt;
  logic              r_rd_busy;
  logic [PAGE_W-1:0] r_rd_page;
  logic              r_rd_fresh;
  logic [PAGE_W-1:0] r_latest;
  logic              r_latest_vld;
  logic              r_latest_consumed;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_proto_err;

  logic [PAGE_W-1:0] w_elig_page;
  logic              w_wr_grant;
  logic              w_rd_grant;
  logic              w_wr_fin;
  logic              w_rd_fin;
  logic              w_bad_done;

  // A page is free when nobody owns it and it is not the newest completed frame;
  // an old latest still held by the reader stays excluded until rd_done.
  always_comb begin
    w_elig_page = '0;
    for (int i = PAGE_NUM - 1; i >= 0; i--) begin
      if (!(r_wr_busy && (r_wr_page == PAGE_W'(i))) &&
          !(r_rd_busy && (r_rd_page == PAGE_W'(i))) &&
          !(r_latest_vld && (r_latest == PAGE_W'(i)))) begin
        w_elig_page = PAGE_W'(i);
      end
    end
  end

  assign w_wr_grant = wr_req && !r_wr_busy && DDR_INIT_DONE;
  assign w_rd_grant = rd_req && !r_rd_busy && DDR_INIT_DONE && r_latest_vld;
  assign w_wr_fin   = wr_done && r_wr_busy;
  assign w_rd_fin   = rd_done && r_rd_busy;
  assign w_bad_done = (wr_done && !r_wr_busy) || (rd_done && !r_rd_busy);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_wr_gnt          <= 1'b0;
      r_wr_busy         <= 1'b0;
      r_wr_page         <= '0;
      r_rd_gnt          <= 1'b0;
      r_rd_busy         <= 1'b0;
      r_rd_page         <= '0;
      r_rd_fresh        <= 1'b0;
      r_latest          <= '0;
      r_latest_vld      <= 1'b0;
      r_latest_consumed <= 1'b0;
      r_drop_cnt        <= '0;
      r_proto_err       <= 1'b0;
    end else begin
      r_wr_gnt <= w_wr_grant;
      r_rd_gnt <= w_rd_grant;

      if (w_wr_grant) begin
        r_wr_page <= w_elig_page;
        r_wr_busy <= 1'b1;
      end else if (w_wr_fin) begin
        r_wr_busy <= 1'b0;
      end

      if (w_rd_grant) begin
        r_rd_page         <= r_latest;
        r_rd_fresh        <= !r_latest_consumed;
        r_rd_busy         <= 1'b1;
        r_latest_consumed <= 1'b1;
      end else if (w_rd_fin) begin
        r_rd_busy <= 1'b0;
      end

      // A completing frame supersedes any same-cycle read of the old latest.
      if (w_wr_fin) begin
        if (r_latest_vld && !r_latest_consumed && (r_drop_cnt != '1)) begin
          r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
        r_latest          <= r_wr_page;
        r_latest_vld      <= 1'b1;
        r_latest_consumed <= 1'b0;
      end

      if (w_bad_done) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign wr_gnt    = r_wr_gnt;
  assign wr_page   = r_wr_page;
  assign wr_busy   = r_wr_busy;
  assign rd_gnt    = r_rd_gnt;
  assign rd_page   = r_rd_page;
  assign rd_fresh  = r_rd_fresh;
  assign rd_busy   = r_rd_busy;
  assign drop_cnt  = r_drop_cnt;
  assign proto_err = r_proto_err;

endmodule
